// File: rtl/openhw_ahb_burst_manager.sv
// AHB-Lite manager: turns one cache/LSU request into a single beat or an
// incrementing line burst, overlapping address and data phases.
module openhw_ahb_burst_manager #(
    parameter int PA_BITS = 34,
    parameter int AHBW    = 64,
    parameter int BEATS   = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       ReqValid,
    output logic                       ReqReady,
    input  logic                       ReqWrite,
    input  logic                       ReqBurst,
    input  logic [PA_BITS-1:0]         ReqAdr,
    input  logic [2:0]                 ReqSize,
    input  logic [AHBW-1:0]            WriteData,
    input  logic [AHBW/8-1:0]          WriteStrb,
    output logic [$clog2(BEATS)-1:0]   WriteBeat,
    output logic [AHBW-1:0]            ReadData,
    output logic                       ReadValid,
    output logic [$clog2(BEATS)-1:0]   ReadBeat,
    output logic                       Done,
    output logic                       Err,
    output logic [PA_BITS-1:0]         HADDR,
    output logic [1:0]                 HTRANS,
    output logic                       HWRITE,
    output logic [2:0]                 HSIZE,
    output logic [2:0]                 HBURST,
    output logic [3:0]                 HPROT,
    output logic                       HMASTLOCK,
    output logic [AHBW-1:0]            HWDATA,
    output logic [AHBW/8-1:0]          HWSTRB,
    input  logic [AHBW-1:0]            HRDATA,
    input  logic                       HREADY,
    input  logic                       HRESP
);
    localparam int BW       = $clog2(BEATS);
    localparam int SW       = AHBW / 8;
    localparam int SZ       = $clog2(SW);
    localparam int LINE_LSB = $clog2(BEATS * SW);
    localparam logic [2:0] BURST_CODE = (BEATS == 8) ? 3'b101 : 3'b011;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LASTDATA, S_ERR2} state_e;

    state_e             state_q, state_d;
    logic [PA_BITS-1:0] adr_q, adr_d;
    logic               write_q, write_d, burst_q, burst_d;
    logic [2:0]         size_q, size_d;
    logic [SW-1:0]      strb_q, strb_d;
    logic [BW-1:0]      adr_cnt_q, adr_cnt_d, dat_cnt_q, dat_cnt_d;
    logic               dphase_q, dphase_d;
    logic [AHBW-1:0]    rdata_q, rdata_d;
    logic [BW-1:0]      rbeat_q, rbeat_d;
    logic               rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
    logic [1:0]         htrans;
    logic               accept, err1, data_ok;
    logic [BW-1:0]      last_beat;

    // Done cycle is not yet ready, so the next accept lands one cycle after Done.
    assign ReqReady  = (state_q == S_IDLE) && !done_q;
    assign accept    = ReqValid && ReqReady;
    assign err1      = dphase_q && HRESP && !HREADY;
    assign data_ok   = dphase_q && HREADY && !HRESP;
    assign last_beat = burst_q ? BW'(BEATS - 1) : '0;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        write_d   = write_q;
        burst_d   = burst_q;
        size_d    = size_q;
        strb_d    = strb_q;
        adr_cnt_d = adr_cnt_q;
        dat_cnt_d = dat_cnt_q;
        dphase_d  = HREADY ? 1'b0 : dphase_q;
        rdata_d   = rdata_q;
        rbeat_d   = rbeat_q;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        htrans    = T_IDLE;

        if (data_ok) begin
            dat_cnt_d = dat_cnt_q + 1'b1;
            if (!write_q) begin
                rvalid_d = 1'b1;
                rdata_d  = HRDATA;
                rbeat_d  = dat_cnt_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_ADDR;
                    adr_d     = ReqAdr;
                    write_d   = ReqWrite;
                    burst_d   = ReqBurst;
                    size_d    = ReqBurst ? 3'(SZ) : ReqSize;
                    strb_d    = ReqBurst ? '1 : WriteStrb;
                    adr_cnt_d = '0;
                    dat_cnt_d = '0;
                end
            end
            S_ADDR: begin
                // Error cycle 1 withdraws the pending address immediately.
                if (err1) begin
                    state_d  = S_ERR2;
                    dphase_d = 1'b0;
                end else begin
                    htrans = (adr_cnt_q == '0) ? T_NONSEQ : T_SEQ;
                    if (HREADY) begin
                        dphase_d  = 1'b1;
                        adr_d     = adr_q + PA_BITS'(SW);
                        adr_cnt_d = adr_cnt_q + 1'b1;
                        if (adr_cnt_q == last_beat) state_d = S_LASTDATA;
                    end
                end
            end
            S_LASTDATA: begin
                if (err1) begin
                    state_d  = S_ERR2;
                    dphase_d = 1'b0;
                end else if (HREADY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = HRESP;
                end
            end
            S_ERR2: begin
                dphase_d = 1'b0;
                if (HREADY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            write_q   <= 1'b0;
            burst_q   <= 1'b0;
            size_q    <= '0;
            strb_q    <= '0;
            adr_cnt_q <= '0;
            dat_cnt_q <= '0;
            dphase_q  <= 1'b0;
            rdata_q   <= '0;
            rbeat_q   <= '0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            write_q   <= write_d;
            burst_q   <= burst_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            adr_cnt_q <= adr_cnt_d;
            dat_cnt_q <= dat_cnt_d;
            dphase_q  <= dphase_d;
            rdata_q   <= rdata_d;
            rbeat_q   <= rbeat_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign WriteBeat = dat_cnt_q;
    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign ReadBeat  = rbeat_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign HADDR     = adr_q;
    assign HTRANS    = htrans;
    assign HWRITE    = write_q;
    assign HSIZE     = size_q;
    assign HBURST    = burst_q ? BURST_CODE : 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = WriteData;
    assign HWSTRB    = strb_q;

    a_line_aligned: assert property (@(posedge HCLK) disable iff (HRESET)
        (ReqValid && ReqReady && ReqBurst) |-> (ReqAdr[LINE_LSB-1:0] == '0));
endmodule

// File: tb/tb_openhw_ahb_burst_manager.sv
// Bench for openhw_ahb_burst_manager: a 4-beat instance for reads/errors/reset
// and an 8-beat instance for the waited INCR8 write; reads go through a scoreboard.
module tb_openhw_ahb_burst_manager;
    logic        HCLK = 1'b0;
    logic        HRESET;
    always #5 HCLK = ~HCLK;

    logic        rv4, rv8, ReqWrite, ReqBurst, HREADY, HRESP;
    logic [33:0] ReqAdr;
    logic [2:0]  ReqSize;
    logic [7:0]  WriteStrb;
    logic [63:0] HRDATA, wd4, wd8;

    logic        rr4, rdv4, done4, err4, hwrite4, hml4;
    logic [1:0]  wb4, rb4, htrans4;
    logic [63:0] rd4, hwdata4;
    logic [33:0] haddr4;
    logic [2:0]  hsize4, hburst4;
    logic [3:0]  hprot4;
    logic [7:0]  hwstrb4;

    logic        rr8, rdv8, done8, err8, hwrite8, hml8;
    logic [2:0]  wb8, rb8;
    logic [1:0]  htrans8;
    logic [63:0] rd8, hwdata8;
    logic [33:0] haddr8;
    logic [2:0]  hsize8, hburst8;
    logic [3:0]  hprot8;
    logic [7:0]  hwstrb8;

    assign wd4 = 64'hA4A4_0000_0000_0000 | 64'(wb4);
    assign wd8 = 64'hD8D8_0000_0000_0000 | 64'(wb8);

    openhw_ahb_burst_manager #(.PA_BITS(34), .AHBW(64), .BEATS(4)) u4 (
        .HCLK(HCLK), .HRESET(HRESET), .ReqValid(rv4), .ReqReady(rr4), .ReqWrite(ReqWrite),
        .ReqBurst(ReqBurst), .ReqAdr(ReqAdr), .ReqSize(ReqSize), .WriteData(wd4),
        .WriteStrb(WriteStrb), .WriteBeat(wb4), .ReadData(rd4), .ReadValid(rdv4),
        .ReadBeat(rb4), .Done(done4), .Err(err4), .HADDR(haddr4), .HTRANS(htrans4),
        .HWRITE(hwrite4), .HSIZE(hsize4), .HBURST(hburst4), .HPROT(hprot4),
        .HMASTLOCK(hml4), .HWDATA(hwdata4), .HWSTRB(hwstrb4), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP));

    openhw_ahb_burst_manager #(.PA_BITS(34), .AHBW(64), .BEATS(8)) u8 (
        .HCLK(HCLK), .HRESET(HRESET), .ReqValid(rv8), .ReqReady(rr8), .ReqWrite(ReqWrite),
        .ReqBurst(ReqBurst), .ReqAdr(ReqAdr), .ReqSize(ReqSize), .WriteData(wd8),
        .WriteStrb(WriteStrb), .WriteBeat(wb8), .ReadData(rd8), .ReadValid(rdv8),
        .ReadBeat(rb8), .Done(done8), .Err(err8), .HADDR(haddr8), .HTRANS(htrans8),
        .HWRITE(hwrite8), .HSIZE(hsize8), .HBURST(hburst8), .HPROT(hprot8),
        .HMASTLOCK(hml8), .HWDATA(hwdata8), .HWSTRB(hwstrb8), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP));

    int checks = 0;
    int failures = 0;
    logic [65:0] sb[$];
    logic [65:0] e;

    // Scoreboard consumer: every ReadValid must match the oldest expected beat.
    always @(negedge HCLK) begin
        if (rdv4) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got beat=%0d data=%h required none", rb4, rd4);
            end else begin
                e = sb.pop_front();
                if ({rb4, rd4} !== e) begin
                    failures++;
                    $display("FAIL rd_data got beat=%0d data=%h required beat=%0d data=%h",
                             rb4, rd4, e[65:64], e[63:0]);
                end
            end
        end
        if (rdv8) begin
            checks++;
            failures++;
            $display("FAIL rd8_unexpected got ReadValid=1 required 0");
        end
    end

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        nxt(); nxt();
        mid();
        checks++; if (rr4 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b req=1", rr4); end
        checks++; if (rr8 !== 1'b1) begin failures++; $display("FAIL rst_ready8 got=%b req=1", rr8); end
        checks++; if (htrans4 !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%b req=00", htrans4); end
        checks++; if (haddr4 !== 34'h0) begin failures++; $display("FAIL rst_haddr got=%h req=0", haddr4); end
        checks++; if ({hwrite4, hburst4, hsize4} !== 7'h0) begin failures++; $display("FAIL rst_ctrl got=%b%b%b req=0", hwrite4, hburst4, hsize4); end
        checks++; if ({done4, err4, rdv4} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b%b%b req=000", done4, err4, rdv4); end
        checks++; if (rd4 !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h req=0", rd4); end
        checks++; if ({wb4, rb4} !== 4'h0) begin failures++; $display("FAIL rst_beats got=%h req=0", {wb4, rb4}); end
        checks++; if ({hprot4, hml4} !== 5'b00110) begin failures++; $display("FAIL rst_const got=%b/%b req=0011/0", hprot4, hml4); end
        nxt();
        HRESET = 1'b0;
    endtask

    task automatic test_single_read();
        nxt(); rv4 = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b0; ReqAdr = 34'h0_8000_0010; ReqSize = 3'd3;
        mid();
        checks++; if (rr4 !== 1'b1) begin failures++; $display("FAIL sr_accept got=%b req=1", rr4); end
        nxt(); rv4 = 1'b0;
        mid();
        checks++; if (htrans4 !== 2'b10) begin failures++; $display("FAIL sr_htrans got=%b req=10", htrans4); end
        checks++; if (hburst4 !== 3'b000) begin failures++; $display("FAIL sr_hburst got=%b req=000", hburst4); end
        checks++; if (haddr4 !== 34'h0_8000_0010) begin failures++; $display("FAIL sr_haddr got=%h req=80000010", haddr4); end
        checks++; if ({hsize4, hwrite4} !== 4'b0110) begin failures++; $display("FAIL sr_ctrl got=%b/%b req=011/0", hsize4, hwrite4); end
        nxt(); HRDATA = 64'h1111_2222_3333_4444; sb.push_back({2'd0, HRDATA});
        mid();
        checks++; if ({htrans4, done4} !== 3'b000) begin failures++; $display("FAIL sr_dphase got=%b/%b req=00/0", htrans4, done4); end
        nxt();
        mid();
        checks++; if ({done4, err4, rdv4} !== 3'b101) begin failures++; $display("FAIL sr_done got=%b%b%b req=101", done4, err4, rdv4); end
        nxt();
        mid();
        checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL sr_done_pulse got=%b req=0", done4); end
    endtask

    task automatic test_incr4_read();
        nxt(); rv4 = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b1; ReqAdr = 34'h0_8000_0040; ReqSize = 3'd0;
        mid();
        checks++; if (rr4 !== 1'b1) begin failures++; $display("FAIL i4_accept got=%b req=1", rr4); end
        for (int c = 1; c <= 6; c++) begin
            nxt(); rv4 = 1'b0;
            if (c >= 2 && c <= 5) begin
                HRDATA = 64'h4000_0000_0000_0000 + 64'(c * 7);
                sb.push_back({2'(c - 2), HRDATA});
            end
            mid();
            if (c <= 4) begin
                checks++; if (htrans4 !== ((c == 1) ? 2'b10 : 2'b11)) begin failures++; $display("FAIL i4_htrans c=%0d got=%b", c, htrans4); end
                checks++; if (haddr4 !== 34'h0_8000_0040 + 34'(8 * (c - 1))) begin failures++; $display("FAIL i4_haddr c=%0d got=%h req=%h", c, haddr4, 34'h0_8000_0040 + 34'(8 * (c - 1))); end
                checks++; if ({hburst4, hsize4} !== 6'b011_011) begin failures++; $display("FAIL i4_ctrl got=%b/%b req=011/011", hburst4, hsize4); end
            end else if (c == 5) begin
                checks++; if ({htrans4, done4} !== 3'b000) begin failures++; $display("FAIL i4_last got=%b/%b req=00/0", htrans4, done4); end
            end else begin
                checks++; if ({done4, err4} !== 2'b10) begin failures++; $display("FAIL i4_done got=%b%b req=10", done4, err4); end
            end
        end
    endtask

    task automatic test_incr8_write();
        int a = 0;
        int d = -1;
        bit w2 = 1'b0;
        bit w5 = 1'b0;
        nxt(); rv8 = 1'b1; ReqWrite = 1'b1; ReqBurst = 1'b1; ReqAdr = 34'h0_8000_0200; WriteStrb = 8'h01;
        mid();
        checks++; if (rr8 !== 1'b1) begin failures++; $display("FAIL i8_accept got=%b req=1", rr8); end
        for (int c = 1; c < 40 && !(a == 8 && d < 0); c++) begin
            nxt(); rv8 = 1'b0; HREADY = 1'b1;
            if (d == 2 && !w2) begin HREADY = 1'b0; w2 = 1'b1; end
            if (d == 5 && !w5) begin HREADY = 1'b0; w5 = 1'b1; end
            mid();
            checks++; if (htrans8 !== ((a < 8) ? ((a == 0) ? 2'b10 : 2'b11) : 2'b00)) begin failures++; $display("FAIL i8_htrans c=%0d got=%b", c, htrans8); end
            checks++; if ({hburst8, hsize8, hwrite8} !== 7'b101_011_1) begin failures++; $display("FAIL i8_ctrl got=%b/%b/%b req=101/011/1", hburst8, hsize8, hwrite8); end
            if (a < 8) begin
                checks++; if (haddr8 !== 34'h0_8000_0200 + 34'(8 * a)) begin failures++; $display("FAIL i8_haddr c=%0d got=%h req=%h", c, haddr8, 34'h0_8000_0200 + 34'(8 * a)); end
            end
            if (d >= 0) begin
                checks++; if (wb8 !== 3'(d)) begin failures++; $display("FAIL i8_wbeat c=%0d got=%0d req=%0d", c, wb8, d); end
                checks++; if (hwdata8 !== (64'hD8D8_0000_0000_0000 | 64'(d))) begin failures++; $display("FAIL i8_hwdata c=%0d got=%h", c, hwdata8); end
                checks++; if (hwstrb8 !== 8'hFF) begin failures++; $display("FAIL i8_hwstrb got=%h req=ff", hwstrb8); end
            end
            checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL i8_early_done c=%0d got=1 req=0", c); end
            if (HREADY) begin
                d = (a < 8) ? a : -1;
                if (a < 8) a++;
            end
        end
        nxt(); HREADY = 1'b1;
        mid();
        checks++; if ({done8, err8} !== 2'b10) begin failures++; $display("FAIL i8_done got=%b%b req=10", done8, err8); end
    endtask

    task automatic test_error();
        nxt(); rv4 = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b1; ReqAdr = 34'h0_8000_0060;
        mid();
        nxt(); rv4 = 1'b0;
        mid();
        checks++; if (htrans4 !== 2'b10) begin failures++; $display("FAIL er_htrans0 got=%b req=10", htrans4); end
        nxt(); HRDATA = 64'hE000_0000_0000_00E0; sb.push_back({2'd0, HRDATA});
        mid();
        checks++; if (haddr4 !== 34'h0_8000_0068) begin failures++; $display("FAIL er_haddr1 got=%h req=80000068", haddr4); end
        nxt(); HRESP = 1'b1; HREADY = 1'b0; HRDATA = 64'hBAD0_BAD0_BAD0_BAD0;
        mid();
        checks++; if (htrans4 !== 2'b00) begin failures++; $display("FAIL er_cycle1_htrans got=%b req=00", htrans4); end
        nxt(); HRESP = 1'b1; HREADY = 1'b1;
        mid();
        checks++; if ({htrans4, done4, rdv4} !== 4'b0000) begin failures++; $display("FAIL er_cycle2 got=%b/%b/%b req=00/0/0", htrans4, done4, rdv4); end
        nxt(); HRESP = 1'b0;
        mid();
        checks++; if ({done4, err4, rdv4} !== 3'b110) begin failures++; $display("FAIL er_done got=%b%b%b req=110", done4, err4, rdv4); end
        nxt();
        mid();
        checks++; if ({done4, err4, rr4} !== 3'b001) begin failures++; $display("FAIL er_after got=%b%b%b req=001", done4, err4, rr4); end
    endtask

    task automatic test_reset_midburst();
        nxt(); rv4 = 1'b1; ReqWrite = 1'b0; ReqBurst = 1'b1; ReqAdr = 34'h0_8000_0080;
        mid();
        nxt(); rv4 = 1'b0;
        mid();
        nxt(); HRDATA = 64'h5555_0000_0000_0001; sb.push_back({2'd0, HRDATA});
        mid();
        nxt(); HRDATA = 64'h5555_0000_0000_0002; HRESET = 1'b1;
        mid();
        checks++; if (haddr4 !== 34'h0_8000_0090) begin failures++; $display("FAIL rm_beat2 got=%h req=80000090", haddr4); end
        nxt(); HRESET = 1'b0;
        mid();
        checks++; if ({htrans4, rr4} !== 3'b001) begin failures++; $display("FAIL rm_idle got=%b/%b req=00/1", htrans4, rr4); end
        checks++; if ({haddr4, hburst4} !== 37'h0) begin failures++; $display("FAIL rm_regs got=%h/%b req=0/000", haddr4, hburst4); end
        checks++; if ({done4, rdv4} !== 2'b00) begin failures++; $display("FAIL rm_flags got=%b%b req=00", done4, rdv4); end
        for (int c = 0; c < 2; c++) begin
            nxt();
            mid();
            checks++; if ({done4, htrans4} !== 3'b000) begin failures++; $display("FAIL rm_no_done got=%b/%b req=0/00", done4, htrans4); end
        end
        nxt(); rv4 = 1'b1; ReqWrite = 1'b1; ReqBurst = 1'b0; ReqAdr = 34'h0_8000_0108; ReqSize = 3'd2; WriteStrb = 8'h0F;
        mid();
        checks++; if (rr4 !== 1'b1) begin failures++; $display("FAIL sw_accept got=%b req=1", rr4); end
        nxt(); rv4 = 1'b0;
        mid();
        checks++; if ({htrans4, hwrite4, hsize4, hburst4} !== 9'b10_1_010_000) begin failures++; $display("FAIL sw_ctrl got=%b/%b/%b/%b", htrans4, hwrite4, hsize4, hburst4); end
        checks++; if (haddr4 !== 34'h0_8000_0108) begin failures++; $display("FAIL sw_haddr got=%h req=80000108", haddr4); end
        nxt();
        mid();
        checks++; if ({wb4, hwstrb4} !== {2'd0, 8'h0F}) begin failures++; $display("FAIL sw_strb got=%0d/%h req=0/0f", wb4, hwstrb4); end
        checks++; if (hwdata4 !== 64'hA4A4_0000_0000_0000) begin failures++; $display("FAIL sw_hwdata got=%h", hwdata4); end
        nxt();
        mid();
        checks++; if ({done4, err4, rdv4} !== 3'b100) begin failures++; $display("FAIL sw_done got=%b%b%b req=100", done4, err4, rdv4); end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1;
        int acc2 = -1;
        int done_c = -1;
        int ns2 = -1;
        logic [1:0]  gap = 2'bxx;
        logic [33:0] a2 = '0;
        for (int c = 0; c < 10; c++) begin
            nxt();
            rv4 = (acc2 < 0); ReqWrite = 1'b0; ReqBurst = 1'b0; ReqSize = 3'd3;
            ReqAdr = (acc1 < 0) ? 34'h0_8000_0020 : 34'h0_8000_0028;
            if (acc1 >= 0 && c == acc1 + 2) begin HRDATA = 64'hB2B0_0000_0000_0001; sb.push_back({2'd0, HRDATA}); end
            if (acc2 >= 0 && c == acc2 + 2) begin HRDATA = 64'hB2B0_0000_0000_0002; sb.push_back({2'd0, HRDATA}); end
            mid();
            if (c == 4) gap = htrans4;
            if (acc2 >= 0 && c > acc2 && ns2 < 0 && htrans4 == 2'b10) begin ns2 = c; a2 = haddr4; end
            if (done4 && done_c < 0) done_c = c;
            if (rr4 && rv4) begin
                if (acc1 < 0) acc1 = c;
                else acc2 = c;
            end
        end
        rv4 = 1'b0;
        checks++; if (acc1 !== 0) begin failures++; $display("FAIL bb_acc1 got=%0d req=0", acc1); end
        checks++; if (done_c !== 3) begin failures++; $display("FAIL bb_done got=%0d req=3", done_c); end
        checks++; if (acc2 !== 4) begin failures++; $display("FAIL bb_acc2 got=%0d req=4", acc2); end
        checks++; if (gap !== 2'b00) begin failures++; $display("FAIL bb_gap got=%b req=00", gap); end
        checks++; if (ns2 !== 5) begin failures++; $display("FAIL bb_nonseq2 got=%0d req=5", ns2); end
        checks++; if (a2 !== 34'h0_8000_0028) begin failures++; $display("FAIL bb_haddr2 got=%h req=80000028", a2); end
    endtask

    initial begin
        HRESET = 1'b1; rv4 = 1'b0; rv8 = 1'b0; ReqWrite = 1'b0; ReqBurst = 1'b0;
        ReqAdr = '0; ReqSize = '0; WriteStrb = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        test_reset();
        test_single_read();
        test_incr4_read();
        test_incr8_write();
        test_error();
        test_reset_midburst();
        test_back_to_back();
        nxt(); nxt();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
